motor_axil_regs: RTL and testbench

//  AXI4-Lite responder for the motor peripheral: the slave end of the S00_AXI port driven by the master VIP.

---
 rtl/motor_axil_pkg.sv | 27 ++
 rtl/motor_pwm_gen.sv | 53 +++++
 rtl/motor_axil_regs.sv | 211 +++++++++++++++++++++
 tb/tb_motor_axil_regs.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_axil_pkg.sv
// Shared constants and state types for the motor AXI4-Lite register block.
package motor_axil_pkg;

  localparam int NUM_REGS = 4;

  // Register index taken from address bits [3:2]
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DUTY    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIR_BIT = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_e;

endpackage

// File: rtl/motor_pwm_gen.sv
// PWM generator with period/duty shadows that reload only on counter wrap,
// so a mid-period register write never produces a truncated pulse.
module motor_pwm_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] per_sh_r;
  logic [CNT_W-1:0] duty_sh_r;
  logic             pwm_r;
  logic             per_zero_s;
  logic             wrap_s;

  // A zero period counts as a wrap every cycle so a new period is picked up at once
  assign per_zero_s = (per_sh_r == CNT_ZERO);
  assign wrap_s     = per_zero_s || (cnt_r == (per_sh_r - CNT_ONE));

  // Counter, shadow reload and registered PWM compare
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= CNT_ZERO;
      per_sh_r  <= CNT_ZERO;
      duty_sh_r <= CNT_ZERO;
      pwm_r     <= 1'b0;
    end else if (!en) begin
      cnt_r     <= CNT_ZERO;
      per_sh_r  <= period;
      duty_sh_r <= duty;
      pwm_r     <= 1'b0;
    end else if (wrap_s) begin
      cnt_r     <= CNT_ZERO;
      per_sh_r  <= period;
      duty_sh_r <= duty;
      pwm_r     <= !per_zero_s && (cnt_r < duty_sh_r);
    end else begin
      cnt_r     <= cnt_r + CNT_ONE;
      pwm_r     <= (cnt_r < duty_sh_r);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/motor_axil_regs.sv
// AXI4-Lite slave holding CTRL/PERIOD/DUTY/SCRATCH and driving the motor pins.
// One outstanding transaction per channel; AW and W are captured independently.
module motor_axil_regs
  import motor_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_CNT_WIDTH      = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            motor_en,
  output logic                            motor_dir,
  output logic                            motor_pwm
);

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_r [NUM_REGS];

  wr_state_e                     wr_state_r;
  wr_state_e                     wr_state_s;
  logic                          aw_full_r;
  logic                          w_full_r;
  logic [1:0]                    aw_idx_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_r;
  logic [NBYTES-1:0]             wstrb_r;
  logic                          aw_hs_s;
  logic                          w_hs_s;
  logic                          wr_fire_s;
  logic [1:0]                    wr_idx_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_s;
  logic [NBYTES-1:0]             wr_strb_s;

  rd_state_e                     rd_state_r;
  rd_state_e                     rd_state_s;
  logic                          ar_hs_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;

  logic                          dir_r;
  logic                          unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready stays low from its own handshake until the write response completes
  assign S_AXI_AWREADY = (wr_state_r == WR_IDLE) && !aw_full_r;
  assign S_AXI_WREADY  = (wr_state_r == WR_IDLE) && !w_full_r;
  assign S_AXI_BVALID  = (wr_state_r == WR_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;

  assign aw_hs_s   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs_s    = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_fire_s = (wr_state_r == WR_IDLE) && (aw_full_r || aw_hs_s) && (w_full_r || w_hs_s);
  assign wr_idx_s  = aw_full_r ? aw_idx_r : S_AXI_AWADDR[3:2];
  assign wr_data_s = w_full_r ? wdata_r : S_AXI_WDATA;
  assign wr_strb_s = w_full_r ? wstrb_r : S_AXI_WSTRB;

  // Write FSM next state
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: begin
        if (wr_fire_s) begin
          wr_state_s = WR_RESP;
        end else begin
          wr_state_s = WR_IDLE;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          wr_state_s = WR_IDLE;
        end else begin
          wr_state_s = WR_RESP;
        end
      end
      default: wr_state_s = WR_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_r <= WR_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
    end
  end

  // Hold whichever of AW/W arrives first until its partner shows up
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      aw_idx_r  <= 2'd0;
      wdata_r   <= {C_S_AXI_DATA_WIDTH{1'b0}};
      wstrb_r   <= {NBYTES{1'b0}};
    end else if (wr_fire_s) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        aw_idx_r  <= S_AXI_AWADDR[3:2];
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        wdata_r  <= S_AXI_WDATA;
        wstrb_r  <= S_AXI_WSTRB;
      end
    end
  end

  // Register file with byte-lane write enables
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {C_S_AXI_DATA_WIDTH{1'b0}};
      end
    end else if (wr_fire_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_strb_s[b]) begin
          regs_r[wr_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
        end
      end
    end
  end

  assign ar_hs_s       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign S_AXI_ARREADY = (rd_state_r == RD_IDLE);
  assign S_AXI_RVALID  = (rd_state_r == RD_VALID);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_r;

  // Read FSM next state
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (S_AXI_ARVALID) begin
          rd_state_s = RD_VALID;
        end else begin
          rd_state_s = RD_IDLE;
        end
      end
      RD_VALID: begin
        if (S_AXI_RREADY) begin
          rd_state_s = RD_IDLE;
        end else begin
          rd_state_s = RD_VALID;
        end
      end
      default: rd_state_s = RD_IDLE;
    endcase
  end

  // Read FSM state and data; sampling regs_r here returns the pre-write value on a collision
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_r <= RD_IDLE;
      rdata_r    <= {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      rd_state_r <= rd_state_s;
      if (ar_hs_s) begin
        rdata_r <= regs_r[S_AXI_ARADDR[3:2]];
      end
    end
  end

  // Direction pin lags CTRL by one register stage
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      dir_r <= 1'b0;
    end else begin
      dir_r <= regs_r[REG_CTRL][CTRL_DIR_BIT];
    end
  end

  assign motor_en  = regs_r[REG_CTRL][CTRL_EN_BIT];
  assign motor_dir = dir_r;

  motor_pwm_gen #(
    .CNT_W (PWM_CNT_WIDTH)
  ) u_pwm (
    .clk    (ACLK),
    .rst    (ARESET),
    .en     (regs_r[REG_CTRL][CTRL_EN_BIT]),
    .period (regs_r[REG_PERIOD][PWM_CNT_WIDTH-1:0]),
    .duty   (regs_r[REG_DUTY][PWM_CNT_WIDTH-1:0]),
    .pwm    (motor_pwm)
  );

endmodule

// File: tb/tb_motor_axil_regs.sv
// Scoreboard bench for motor_axil_regs: expected B/R responses are queued at
// issue time and a negedge monitor checks them when the DUT presents them.
module tb_motor_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        motor_en;
  logic        motor_dir;
  logic        motor_pwm;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int b_seen    = 0;
  int r_seen    = 0;
  logic [1:0]  b_exp_q[$];
  logic [31:0] r_exp_q[$];

  always #5 ACLK = ~ACLK;

  motor_axil_regs dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .motor_en      (motor_en),
    .motor_dir     (motor_dir),
    .motor_pwm     (motor_pwm)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL %s: got no handshake expected one within the cycle budget", name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard monitor: pops an expectation whenever a B or R beat completes
  always @(negedge ACLK) begin
    logic [31:0] exp_d;
    if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
      if (b_exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected: got BVALID=1 expected no response");
      end else begin
        exp_d = {30'd0, b_exp_q.pop_front()};
        check32("bresp", {30'd0, S_AXI_BRESP}, exp_d);
      end
      b_seen++;
    end
    if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
      if (r_exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL r_unexpected: got RVALID=1 expected no response");
      end else begin
        exp_d = r_exp_q.pop_front();
        check32("rdata", S_AXI_RDATA, exp_d);
        check32("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
      end
      r_seen++;
    end
  end

  task automatic wait_b(input int target);
    int n = 0;
    while (b_seen < target && n < 30) begin tick(); n++; end
    if (b_seen < target) timeout("b_wait");
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r_seen < target && n < 30) begin tick(); n++; end
    if (r_seen < target) timeout("r_wait");
  endtask

  // Drives whatever AW/W valids are currently raised until both are accepted
  task automatic hs_write();
    bit a_done = !S_AXI_AWVALID;
    bit w_done = !S_AXI_WVALID;
    int n = 0;
    while (!(a_done && w_done) && n < 30) begin
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) a_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      tick();
      if (a_done) S_AXI_AWVALID = 1'b0;
      if (w_done) S_AXI_WVALID = 1'b0;
      n++;
    end
    if (!(a_done && w_done)) begin
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      timeout("aw_w_hs");
    end
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int target = b_seen + 1;
    b_exp_q.push_back(2'b00);
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    hs_write();
    wait_b(target);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
    int target = r_seen + 1;
    int n = 0;
    bit done = 1'b0;
    r_exp_q.push_back(exp);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    while (!done && n < 30) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) done = 1'b1;
      tick();
      if (done) S_AXI_ARVALID = 1'b0;
      n++;
    end
    if (!done) begin
      S_AXI_ARVALID = 1'b0;
      timeout("ar_hs");
    end
    wait_r(target);
  endtask

  // Measures one high run then one low run of motor_pwm, in cycles
  task automatic pwm_runs(output int hi, output int lo);
    int n = 0;
    @(negedge ACLK);
    while (motor_pwm !== 1'b0 && n < 40) begin @(negedge ACLK); n++; end
    while (motor_pwm !== 1'b1 && n < 80) begin @(negedge ACLK); n++; end
    hi = 0;
    while (motor_pwm === 1'b1 && hi < 40) begin hi++; @(negedge ACLK); end
    lo = 0;
    while (motor_pwm === 1'b0 && lo < 40) begin lo++; @(negedge ACLK); end
    tick();
  endtask

  task automatic count_high(input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(negedge ACLK);
      if (motor_pwm === 1'b1) hi++;
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int lo;
    int t1;
    ARESET = 1'b1;
    S_AXI_AWADDR = 4'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 4'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;

    @(negedge ACLK);
    check32("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    check32("rst_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    check32("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    check32("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
    check32("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
    check32("rst_rdata", S_AXI_RDATA, 32'd0);
    check32("rst_motor", {29'd0, motor_en, motor_dir, motor_pwm}, 32'd0);
    tick();

    // Basic write/readback; address bits [1:0] are ignored
    do_write(4'h0, 32'd1, 4'hF);
    do_write(4'h4, 32'd2, 4'hF);
    do_write(4'h8, 32'd3, 4'hF);
    do_write(4'hC, 32'd4, 4'hF);
    do_read(4'h0, 32'd1);
    do_read(4'h4, 32'd2);
    do_read(4'h8, 32'd3);
    do_read(4'hC, 32'd4);
    do_read(4'h5, 32'd2);

    // Byte strobes
    do_write(4'hC, 32'hAABBCCDD, 4'hF);
    do_write(4'hC, 32'h11223344, 4'b0010);
    do_read(4'hC, 32'hAABB33DD);

    // W three cycles ahead of AW
    b_exp_q.push_back(2'b00);
    t1 = b_seen + 1;
    S_AXI_AWADDR = 4'h8;
    S_AXI_WDATA  = 32'h000000A5;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    check32("early_w_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    tick();
    S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check32("early_w_wready_low", {31'd0, S_AXI_WREADY}, 32'd0);
      check32("early_w_no_b", {31'd0, S_AXI_BVALID}, 32'd0);
      tick();
    end
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    check32("late_aw_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    check32("late_aw_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    wait_b(t1);
    do_read(4'h8, 32'h000000A5);

    // Back-pressure on B blocks a second write
    S_AXI_BREADY = 1'b0;
    b_exp_q.push_back(2'b00);
    t1 = b_seen + 2;
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'd5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WDATA = 32'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check32("bhold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      check32("bhold_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
      check32("bhold_wready", {31'd0, S_AXI_WREADY}, 32'd0);
      tick();
    end
    b_exp_q.push_back(2'b00);
    S_AXI_BREADY = 1'b1;
    hs_write();
    wait_b(t1);
    do_read(4'hC, 32'd6);

    // PWM 3 high / 7 low
    do_write(4'h4, 32'd10, 4'hF);
    do_write(4'h8, 32'd3, 4'hF);
    do_write(4'h0, 32'd1, 4'hF);
    @(negedge ACLK);
    check32("pwm_en_dir", {30'd0, motor_en, motor_dir}, 32'd2);
    tick();
    pwm_runs(hi, lo);
    check32("pwm_high_run", hi, 32'd3);
    check32("pwm_low_run", lo, 32'd7);
    pwm_runs(hi, lo);
    check32("pwm_high_run2", hi, 32'd3);
    check32("pwm_low_run2", lo, 32'd7);

    // DUTY above PERIOD gives a constant high after the next wrap
    do_write(4'h8, 32'd12, 4'hF);
    repeat (12) tick();
    count_high(20, hi);
    check32("pwm_duty_gt_period", hi, 32'd20);

    do_write(4'h0, 32'd3, 4'hF);
    @(negedge ACLK);
    check32("dir_set", {30'd0, motor_en, motor_dir}, 32'd3);
    tick();

    // PERIOD zero holds the output low
    do_write(4'h4, 32'd0, 4'hF);
    repeat (12) tick();
    count_high(20, hi);
    check32("pwm_period_zero", hi, 32'd0);

    // Disable forces the output low even with DUTY > PERIOD
    do_write(4'h4, 32'd10, 4'hF);
    repeat (12) tick();
    do_write(4'h0, 32'd0, 4'hF);
    count_high(20, hi);
    check32("pwm_disabled", hi, 32'd0);
    @(negedge ACLK);
    check32("disabled_en", {31'd0, motor_en}, 32'd0);
    tick();

    // Reset after AW, before W
    S_AXI_AWADDR = 4'h4;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    check32("midrst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check32("midrst_no_b", {31'd0, S_AXI_BVALID}, 32'd0);
      check32("midrst_awready_back", {31'd0, S_AXI_AWREADY}, 32'd1);
      tick();
    end
    do_read(4'h0, 32'd0);
    do_read(4'h4, 32'd0);
    do_read(4'h8, 32'd0);
    do_read(4'hC, 32'd0);

    check32("b_queue_empty", b_exp_q.size(), 32'd0);
    check32("r_queue_empty", r_exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
